random_range_sampler: RTL and testbench

Downstream consumer of the LFSR-based random number generator. Each cycle it takes the generator's raw word, reduces it to an unbiased value in [0, bound) by mask-and-reject sampling, and buffers accepted values in a small FIFO. A valid/ready handshake delivers them to stimulus logic. Upstream is never stalled: the generator free-runs, and candidates that cannot be stored are dropped.

---
 rtl/random_range_sampler.sv | 126 ++++++++++++
 tb/tb_random_range_sampler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_range_sampler.sv
// random_range_sampler
// Reduces a free-running random word to an unbiased value in [0, bound)
// using mask-and-reject sampling. Accepted values pass through a one-entry
// candidate register into a small FIFO, which a valid/ready handshake drains.
// The generator is never stalled; candidates that find no room are dropped.
// Optional feature: define RANDOM_RANGE_STATS_EN to enable the saturating
// reject_count statistic (rejected plus dropped candidates).

module random_range_sampler #(
    parameter int RANDOM_WIDTH = 32,
    parameter int OUT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [RANDOM_WIDTH-1:0] random_number,
    input  logic                    sample_en,
    input  logic [OUT_WIDTH-1:0]    bound,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [15:0]             reject_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [OUT_WIDTH-1:0] bound_m1;
    logic [OUT_WIDTH-1:0] mask;
    logic [OUT_WIDTH-1:0] cand;
    logic                 accept;

    logic                 c_valid;
    logic [OUT_WIDTH-1:0] c_data;

    logic [OUT_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 full;
    logic                 pop;
    logic                 push;

    // Only the low OUT_WIDTH bits of the random word are sampled.
    logic unused_random;
    assign unused_random = ^random_number;

    // Smear bound-1 rightwards to form the smallest all-ones mask covering it,
    // then accept the masked candidate only if it falls below the bound.
    always_comb begin
        bound_m1 = bound - OUT_WIDTH'(1);
        mask     = bound_m1;
        for (int s = 1; s < OUT_WIDTH; s = s * 2) begin
            mask = mask | (mask >> s);
        end
        cand   = random_number[OUT_WIDTH-1:0] & mask;
        accept = (bound == '0) || (cand < bound);
    end

    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = storage[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = c_valid & (~full | pop);

    // Candidate register: holds the accepted value for one cycle before FIFO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_valid <= 1'b0;
            c_data  <= '0;
        end else begin
            c_valid <= sample_en & accept;
            c_data  <= cand;
        end
    end

    // FIFO storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                storage[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= c_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RANDOM_RANGE_STATS_EN
    logic        drop;
    logic [1:0]  reject_inc;
    logic [16:0] reject_sum;

    assign drop       = c_valid & ~push;
    assign reject_inc = {1'b0, sample_en & ~accept} + {1'b0, drop};
    assign reject_sum = {1'b0, reject_count} + 17'(reject_inc);

    // Saturating count of rejected and dropped candidates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reject_count <= '0;
        end else if (reject_sum > 17'h0FFFF) begin
            reject_count <= 16'hFFFF;
        end else begin
            reject_count <= reject_sum[15:0];
        end
    end
`else
    assign reject_count = 16'h0000;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// tb_random_range_sampler
// Randomised and directed stimulus for random_range_sampler, checked every
// cycle against a queue-based behavioural model, with a few literal pins.
// Honours RANDOM_RANGE_STATS_EN for the reject_count expectations.

module tb_random_range_sampler;

    localparam int RW = 32;
    localparam int OW = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_n;
    logic [RW-1:0] random_number;
    logic          sample_en;
    logic [OW-1:0] bound;
    logic          out_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [15:0]   reject_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [OW-1:0] m_q[$];
    logic          m_slot_v;
    logic [OW-1:0] m_slot_d;
    int            m_rej;

    random_range_sampler #(
        .RANDOM_WIDTH(RW),
        .OUT_WIDTH(OW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .random_number(random_number),
        .sample_en(sample_en),
        .bound(bound),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .reject_count(reject_count)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: plain arithmetic on the candidate slot and a queue
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_slot_v = 1'b0;
            m_slot_d = '0;
            m_rej    = 0;
        end else begin
            int b;
            int m;
            int c;
            bit acc;
            bit popped;
            bit dropped;
            b = (bound == 0) ? 256 : int'(bound);
            m = 0;
            while (m < b - 1) m = m * 2 + 1;
            c = int'(random_number[7:0]) & m;
            acc = (c < b);
            popped = (m_q.size() > 0) && out_ready;
            if (popped) void'(m_q.pop_front());
            dropped = 1'b0;
            if (m_slot_v) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_slot_d);
                else dropped = 1'b1;
            end
            m_rej = m_rej + ((sample_en && !acc) ? 1 : 0) + (dropped ? 1 : 0);
            if (m_rej > 65535) m_rej = 65535;
            m_slot_v = sample_en && acc;
            m_slot_d = OW'(c);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (reset_n) begin
            check_output("out_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
            if (m_q.size() != 0) check_output("out_data", int'(out_data), int'(m_q[0]));
`ifdef RANDOM_RANGE_STATS_EN
            check_output("reject_count", int'(reject_count), m_rej);
`else
            check_output("reject_count", int'(reject_count), 0);
`endif
        end
    end

    task automatic apply_stimulus(input logic se, input logic [RW-1:0] rn,
                                  input logic [OW-1:0] bnd, input logic rdy);
        sample_en     = se;
        random_number = rn;
        bound         = bnd;
        out_ready     = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        sample_en     = 1'b0;
        random_number = '0;
        bound         = '0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [OW-1:0] vals [8];
    logic [OW-1:0] bsel [8];

    initial begin
        reset_n = 1'b0;
        sample_en = 1'b0;
        random_number = '0;
        bound = '0;
        out_ready = 1'b0;
        bsel[0] = 8'd0;  bsel[1] = 8'd1;   bsel[2] = 8'd2;   bsel[3] = 8'd3;
        bsel[4] = 8'd10; bsel[5] = 8'd100; bsel[6] = 8'd128; bsel[7] = 8'd255;
        @(negedge clk);
        do_reset();

        // Full range: low byte passes straight through
        apply_stimulus(1'b1, 32'h1234_56AB, 8'd0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("full_range_valid", int'(out_valid), 1);
        check_output("full_range_data", int'(out_data), 8'hAB);
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);

        // Rejection with bound 10
        do_reset();
        apply_stimulus(1'b1, 32'hDEAD_BE07, 8'd10, 1'b0);
        apply_stimulus(1'b1, 32'hDEAD_BE0C, 8'd10, 1'b0);
        apply_stimulus(1'b1, 32'hDEAD_BE09, 8'd10, 1'b0);
        apply_stimulus(1'b0, 32'h0, 8'd10, 1'b0);
        check_output("reject_head0", int'(out_data), 7);
`ifdef RANDOM_RANGE_STATS_EN
        check_output("reject_cnt", int'(reject_count), 1);
`endif
        apply_stimulus(1'b0, 32'h0, 8'd10, 1'b1);
        check_output("reject_head1", int'(out_data), 9);
        apply_stimulus(1'b0, 32'h0, 8'd10, 1'b1);
        check_output("reject_empty", int'(out_valid), 0);

        // Backpressure then full-with-pop then drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [RW-1:0] rn;
            rn = $urandom;
            vals[i] = rn[7:0];
            apply_stimulus(1'b1, rn, 8'd0, 1'b0);
`ifdef RANDOM_RANGE_STATS_EN
            if (i == 6) check_output("bp_drops", int'(reject_count), 2);
`endif
        end
        check_output("bp_valid", int'(out_valid), 1);
        check_output("bp_head", int'(out_data), int'(vals[0]));
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("fullpop_valid", int'(out_valid), 1);
        check_output("fullpop_head", int'(out_data), int'(vals[1]));
`ifdef RANDOM_RANGE_STATS_EN
        check_output("fullpop_nodrop", int'(reject_count), 3);
`endif
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("drain2", int'(out_data), int'(vals[2]));
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("drain3", int'(out_data), int'(vals[3]));
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("drain7", int'(out_data), int'(vals[7]));
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("drain_empty", int'(out_valid), 0);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, $urandom, 8'd0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b0);
        check_output("pre_reset_valid", int'(out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_valid", int'(out_valid), 0);
        check_output("async_reset_data", int'(out_data), 0);
        check_output("async_reset_rej", int'(reject_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b0, 32'h0, 8'd0, 1'b1);
        check_output("post_reset_valid", int'(out_valid), 0);

        // bound = 1: every accepted value is zero
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, 8'd1, 1'($urandom_range(0, 1)));
            if (out_valid) check_output("bound1_zero", int'(out_data), 0);
        end
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, $urandom, 8'd1, 1'b1);
        check_output("sample_off_empty", int'(out_valid), 0);

        // Random phase with occasional bound changes and one mid-run reset
        begin
            logic [OW-1:0] cur_bound;
            cur_bound = 8'd10;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 1) cur_bound = bsel[$urandom_range(0, 7)];
                    else cur_bound = 8'($urandom);
                end
                if (i == 300) begin
                    #3;
                    reset_n = 1'b0;
                    #1;
                    check_output("rand_reset_valid", int'(out_valid), 0);
                    @(negedge clk);
                    reset_n = 1'b1;
                end
                apply_stimulus(1'($urandom_range(0, 3) != 0), $urandom, cur_bound,
                               1'($urandom_range(0, 2) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
